// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider initiator (div_ctrl).
// Holds the controller state encoding, the handshake level constants
// and the data widths.
package div_ctrl_pkg;

  localparam int unsigned DataW   = 32;
  localparam int unsigned ResultW = 64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_HOLD = 2'd2
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivCancel         = 1'b1;
  localparam logic DivNoCancel       = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [DataW-1:0] zeroword = 32'h0000_0000;

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage initiator for the multi-cycle divider.
// Accepts DIV/DIVU from EX, drives start/sign/operands/cancel to the
// divider, stalls the pipeline until the result returns, aborts on flush
// and presents {remainder, quotient} as {HI, LO} for writeback.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   div_req, div_signed EX holds a DIV (signed=1) or DIVU (signed=0)
//   opnd1, opnd2        dividend, divisor
//   flush               abort the current operation (highest priority)
//   ex_stall            EX held by a downstream stall
//   div_result/div_done result and ready from the divider
//   div_start, div_cancel, div_sign, div_opdata1/2   registered to divider
//   stallreq            combinational stall request to pipeline control
//   result_o/result_valid  {HI, LO} for EX writeback (valid this cycle)
//
// Build option: define DIV_CTRL_FASTPATH_EN to resolve divisors 0 and 1
// in the request cycle without using the divider.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               div_req,
  input  logic               div_signed,
  input  logic [DataW-1:0]   opnd1,
  input  logic [DataW-1:0]   opnd2,
  input  logic               flush,
  input  logic               ex_stall,
  input  logic [ResultW-1:0] div_result,
  input  logic               div_done,
  output logic               div_start,
  output logic               div_cancel,
  output logic               div_sign,
  output logic [DataW-1:0]   div_opdata1,
  output logic [DataW-1:0]   div_opdata2,
  output logic               stallreq,
  output logic [ResultW-1:0] result_o,
  output logic               result_valid
);

  div_state_e         state_q, state_d;
  logic               start_d, cancel_d, sign_d;
  logic [DataW-1:0]   op1_d, op2_d;
  logic [ResultW-1:0] cap_q, cap_d;
  logic               fast_hit;
  logic [ResultW-1:0] fast_result;

  // Divisor 0 gives 0; divisor 1 gives HI = 0, LO = dividend (any signedness).
`ifdef DIV_CTRL_FASTPATH_EN
  assign fast_hit = (opnd2 == zeroword) || (opnd2 == 32'd1);
`else
  assign fast_hit = 1'b0;
`endif
  assign fast_result = (opnd2 == zeroword) ? {zeroword, zeroword}
                                           : {zeroword, opnd1};

  // State and divider-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      div_start   <= DivStop;
      div_cancel  <= DivNoCancel;
      div_sign    <= 1'b0;
      div_opdata1 <= zeroword;
      div_opdata2 <= zeroword;
      cap_q       <= {zeroword, zeroword};
    end else begin
      state_q     <= state_d;
      div_start   <= start_d;
      div_cancel  <= cancel_d;
      div_sign    <= sign_d;
      div_opdata1 <= op1_d;
      div_opdata2 <= op2_d;
      cap_q       <= cap_d;
    end
  end

  // Next state, next register values and combinational outputs.
  always_comb begin
    state_d      = state_q;
    start_d      = div_start;
    cancel_d     = DivNoCancel;
    sign_d       = div_sign;
    op1_d        = div_opdata1;
    op2_d        = div_opdata2;
    cap_d        = cap_q;
    stallreq     = 1'b0;
    result_valid = 1'b0;
    result_o     = {zeroword, zeroword};

    // Combinational outputs are forced to their reset values during rst.
    if (!rst) begin
      if (flush) begin
        state_d  = DIV_IDLE;
        start_d  = DivStop;
        cancel_d = DivCancel;
      end else begin
        unique case (state_q)
          DIV_IDLE: begin
            if (div_req) begin
              if (fast_hit) begin
                result_valid = 1'b1;
                result_o     = fast_result;
                cap_d        = fast_result;
                if (ex_stall) state_d = DIV_HOLD;
              end else begin
                stallreq = 1'b1;
                start_d  = DivStart;
                sign_d   = div_signed;
                op1_d    = opnd1;
                op2_d    = opnd2;
                state_d  = DIV_BUSY;
              end
            end
          end
          DIV_BUSY: begin
            if (div_done == DivResultReady) begin
              result_valid = 1'b1;
              result_o     = div_result;
              cap_d        = div_result;
              start_d      = DivStop;
              state_d      = ex_stall ? DIV_HOLD : DIV_IDLE;
            end else begin
              stallreq = 1'b1;
            end
          end
          DIV_HOLD: begin
            result_valid = 1'b1;
            result_o     = cap_q;
            if (!ex_stall) state_d = DIV_IDLE;
          end
          default: state_d = DIV_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed testbench for div_ctrl with a behavioural divider model
// (35-cycle latency, short latency for a zero divisor, done held until
// start drops, cancel honoured only while computing).
module tb_div_ctrl;

  logic        clk, rst;
  logic        div_req, div_signed, flush, ex_stall;
  logic [31:0] opnd1, opnd2;
  logic [63:0] div_result;
  logic        div_done;
  logic        div_start, div_cancel, div_sign;
  logic [31:0] div_opdata1, div_opdata2;
  logic        stallreq, result_valid;
  logic [63:0] result_o;

  int checks = 0;
  int errors = 0;

  div_ctrl dut (
    .clk(clk), .rst(rst), .div_req(div_req), .div_signed(div_signed),
    .opnd1(opnd1), .opnd2(opnd2), .flush(flush), .ex_stall(ex_stall),
    .div_result(div_result), .div_done(div_done),
    .div_start(div_start), .div_cancel(div_cancel), .div_sign(div_sign),
    .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .stallreq(stallreq), .result_o(result_o), .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model
  int          m_st, m_cnt, m_lat;
  logic [63:0] m_res;

  function automatic logic [63:0] div_calc(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0; m_cnt <= 0; m_lat <= 0; m_res <= 64'd0;
      div_done <= 1'b0; div_result <= 64'd0;
    end else begin
      case (m_st)
        0: if (div_start && !div_cancel) begin
          m_st  <= 1;
          m_cnt <= 0;
          m_lat <= (div_opdata2 == 32'd0) ? 0 : 33;
          m_res <= div_calc(div_sign, div_opdata1, div_opdata2);
        end
        1: if (div_cancel) m_st <= 0;
           else if (m_cnt == m_lat) begin
             m_st <= 2; div_done <= 1'b1; div_result <= m_res;
           end else m_cnt <= m_cnt + 1;
        default: if (!div_start) begin
          m_st <= 0; div_done <= 1'b0; div_result <= 64'd0;
        end
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Issue one divide, hold ex_stall for `hold` cycles from the result cycle,
  // and report what was observed. Returns at negedge+1 of the following idle cycle.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold,
                         output int stall_cnt, output int valid_cnt, output logic [63:0] res,
                         output logic res_stable, output logic start_seen,
                         output logic start_in_hold, output logic ops_bad,
                         output logic overlap, output logic timeout);
    int   hold_left;
    logic fin;
    hold_left = hold; fin = 1'b0;
    stall_cnt = 0; valid_cnt = 0; res = 64'd0; res_stable = 1'b1;
    start_seen = 1'b0; start_in_hold = 1'b0; ops_bad = 1'b0; overlap = 1'b0;
    @(negedge clk);
    div_req = 1'b1; div_signed = sgn; opnd1 = a; opnd2 = b; ex_stall = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      #1;
      if (stallreq && result_valid) overlap = 1'b1;
      if (div_start) begin
        start_seen = 1'b1;
        if (div_sign !== sgn || div_opdata1 !== a || div_opdata2 !== b) ops_bad = 1'b1;
      end
      if (result_valid) begin
        if (valid_cnt == 0) res = result_o;
        else begin
          if (result_o !== res) res_stable = 1'b0;
          if (div_start) start_in_hold = 1'b1;
        end
        valid_cnt++;
        if (hold_left > 0) begin ex_stall = 1'b1; hold_left--; end
        else begin ex_stall = 1'b0; fin = 1'b1; end
      end else if (stallreq) stall_cnt++;
      @(negedge clk);
    end
    timeout = !fin;
    div_req = 1'b0; ex_stall = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; div_req = 1'b1; div_signed = 1'b1; opnd1 = 32'd100; opnd2 = 32'd7;
    flush = 1'b0; ex_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b exp 0", div_start); end
    checks++; if (div_cancel !== 1'b0) begin errors++; $display("FAIL reset_cancel: got %b exp 0", div_cancel); end
    checks++; if (div_sign !== 1'b0) begin errors++; $display("FAIL reset_sign: got %b exp 0", div_sign); end
    checks++; if ({div_opdata1, div_opdata2} !== 64'd0) begin errors++; $display("FAIL reset_opdata: got %h %h exp 0", div_opdata1, div_opdata2); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %b exp 0", stallreq); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", result_valid); end
    checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h exp 0", result_o); end
    div_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int sc, vc; logic [63:0] r; logic st, ss, sh, ob, ov, to;
    run_div(1'b0, 32'd100, 32'd7, 0, sc, vc, r, st, ss, sh, ob, ov, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL divu_timeout: got %b exp 0", to); end
    checks++; if (r !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_result: got %h exp 000000020000000e", r); end
    checks++; if (sc !== 36) begin errors++; $display("FAIL divu_stall_cycles: got %0d exp 36", sc); end
    checks++; if (vc !== 1) begin errors++; $display("FAIL divu_valid_cycles: got %0d exp 1", vc); end
    checks++; if (ss !== 1'b1 || ob !== 1'b0) begin errors++; $display("FAIL divu_start_ops: seen %b bad %b exp 1 0", ss, ob); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL divu_stall_valid_overlap: got %b exp 0", ov); end
    checks++; if (div_start !== 1'b0 || result_valid !== 1'b0 || stallreq !== 1'b0) begin
      errors++; $display("FAIL divu_after: start %b valid %b stall %b exp 0 0 0", div_start, result_valid, stallreq); end
  endtask

  task automatic test_signed();
    int sc, vc; logic [63:0] r; logic st, ss, sh, ob, ov, to;
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 0, sc, vc, r, st, ss, sh, ob, ov, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL div_timeout: got %b exp 0", to); end
    checks++; if (r !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_result: got %h exp fffffffffffffffd", r); end
    checks++; if (ob !== 1'b0) begin errors++; $display("FAIL div_sign_ops: bad %b exp 0", ob); end
    checks++; if (sc !== 36) begin errors++; $display("FAIL div_stall_cycles: got %0d exp 36", sc); end
  endtask

  task automatic test_flush();
    int sc, vc; logic [63:0] r; logic st, ss, sh, ob, ov, to;
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b0; opnd1 = 32'd1000; opnd2 = 32'd3;
    repeat (11) @(negedge clk);
    flush = 1'b1; #1;
    checks++; if (stallreq !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL flush_cycle: stall %b valid %b exp 0 0", stallreq, result_valid); end
    @(negedge clk); flush = 1'b0; div_req = 1'b0; #1;
    checks++; if (div_cancel !== 1'b1 || div_start !== 1'b0) begin
      errors++; $display("FAIL flush_cancel: cancel %b start %b exp 1 0", div_cancel, div_start); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL flush_no_result: got %b exp 0", result_valid); end
    @(negedge clk); #1;
    checks++; if (div_cancel !== 1'b0) begin errors++; $display("FAIL flush_cancel_pulse: got %b exp 0", div_cancel); end
    run_div(1'b0, 32'd9, 32'd3, 0, sc, vc, r, st, ss, sh, ob, ov, to);
    checks++; if (r !== 64'h00000000_00000003 || to !== 1'b0) begin
      errors++; $display("FAIL flush_next_result: got %h timeout %b exp 0000000000000003 0", r, to); end
    checks++; if (sc !== 36) begin errors++; $display("FAIL flush_next_stall: got %0d exp 36", sc); end
  endtask

  task automatic test_ex_stall();
    int sc, vc; logic [63:0] r; logic st, ss, sh, ob, ov, to;
    run_div(1'b0, 32'd100, 32'd7, 3, sc, vc, r, st, ss, sh, ob, ov, to);
    checks++; if (vc !== 4) begin errors++; $display("FAIL hold_valid_cycles: got %0d exp 4", vc); end
    checks++; if (st !== 1'b1 || r !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL hold_result: got %h stable %b exp 000000020000000e 1", r, st); end
    checks++; if (sh !== 1'b0) begin errors++; $display("FAIL hold_start_low: got %b exp 0", sh); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL hold_overlap: got %b exp 0", ov); end
    @(negedge clk); #1;
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL hold_no_restart: got %b exp 0", div_start); end
  endtask

  task automatic test_done_flush();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b0; opnd1 = 32'd100; opnd2 = 32'd7;
    for (int c = 0; c < 100 && !seen; c++) begin
      #1;
      if (div_done) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL doneflush_done_seen: got %b exp 1", seen); end
    flush = 1'b1; #1;
    checks++; if (result_valid !== 1'b0 || stallreq !== 1'b0) begin
      errors++; $display("FAIL doneflush_discard: valid %b stall %b exp 0 0", result_valid, stallreq); end
    @(negedge clk); flush = 1'b0; div_req = 1'b0; #1;
    checks++; if (div_cancel !== 1'b1 || result_valid !== 1'b0) begin
      errors++; $display("FAIL doneflush_cancel: cancel %b valid %b exp 1 0", div_cancel, result_valid); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int sc, vc; logic [63:0] r; logic st, ss, sh, ob, ov, to;
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b1; opnd1 = 32'd50; opnd2 = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (div_start !== 1'b0 || div_sign !== 1'b0 || div_opdata1 !== 32'd0 || stallreq !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: start %b sign %b op1 %h stall %b exp 0 0 0 0", div_start, div_sign, div_opdata1, stallreq); end
    rst = 1'b0; div_req = 1'b0;
    run_div(1'b0, 32'd100, 32'd7, 0, sc, vc, r, st, ss, sh, ob, ov, to);
    checks++; if (r !== 64'h00000002_0000000E || sc !== 36) begin
      errors++; $display("FAIL midreset_recover: got %h stall %0d exp 000000020000000e 36", r, sc); end
  endtask

`ifdef DIV_CTRL_FASTPATH_EN
  task automatic test_fastpath();
    int sc, vc; logic [63:0] r; logic st, ss, sh, ob, ov, to;
    run_div(1'b1, 32'h80000000, 32'd1, 0, sc, vc, r, st, ss, sh, ob, ov, to);
    checks++; if (r !== 64'h00000000_80000000) begin errors++; $display("FAIL fast_div1_result: got %h exp 0000000080000000", r); end
    checks++; if (sc !== 0 || vc !== 1) begin errors++; $display("FAIL fast_div1_timing: stall %0d valid %0d exp 0 1", sc, vc); end
    checks++; if (ss !== 1'b0) begin errors++; $display("FAIL fast_div1_no_start: got %b exp 0", ss); end
    run_div(1'b0, 32'd5, 32'd0, 0, sc, vc, r, st, ss, sh, ob, ov, to);
    checks++; if (r !== 64'd0 || sc !== 0 || ss !== 1'b0) begin
      errors++; $display("FAIL fast_div0: got %h stall %0d start %b exp 0 0 0", r, sc, ss); end
  endtask
`else
  task automatic test_zero_divisor();
    int sc, vc; logic [63:0] r; logic st, ss, sh, ob, ov, to;
    run_div(1'b0, 32'd5, 32'd0, 0, sc, vc, r, st, ss, sh, ob, ov, to);
    checks++; if (r !== 64'd0 || to !== 1'b0) begin errors++; $display("FAIL zero_div_result: got %h timeout %b exp 0 0", r, to); end
    checks++; if (ss !== 1'b1) begin errors++; $display("FAIL zero_div_start: got %b exp 1", ss); end
    checks++; if (sc !== 3) begin errors++; $display("FAIL zero_div_stall: got %0d exp 3", sc); end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_flush();
    test_ex_stall();
    test_done_flush();
    test_reset_mid();
`ifdef DIV_CTRL_FASTPATH_EN
    test_fastpath();
`else
    test_zero_divisor();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Initiator side of the multi-cycle divider handshake, located in the EX stage beside the divider. It accepts DIV/DIVU from EX, drives start/sign/operands/cancel to the divider, and stalls the pipeline until a result returns. It aborts the operation on flush and presents the 64-bit {remainder, quotient} to EX for the HI/LO write.

## Interface
- No parameters.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- div_req  in  1  EX holds a valid DIV/DIVU.
- div_signed  in  1  1 = DIV, 0 = DIVU.
- opnd1  in  32  dividend.
- opnd2  in  32  divisor.
- flush  in  1  pipeline flush or exception; abort the operation.
- ex_stall  in  1  EX is held by a downstream stall.
- div_result  in  64  from divider: {rem[63:32], quot[31:0]}.
- div_done  in  1  from divider: result ready.
- div_start  out  1  to divider; registered.
- div_cancel  out  1  to divider; registered one-cycle pulse.
- div_sign  out  1  to divider; registered.
- div_opdata1  out  32  to divider; registered.
- div_opdata2  out  32  to divider; registered.
- stallreq  out  1  stall request to pipeline control; combinational.
- result_o  out  64  {HI, LO} for EX writeback.
- result_valid  out  1  result_o is valid this cycle.

## Operation
- Reset values: state IDLE; div_start, div_cancel, div_sign = 0; div_opdata1/2 = 0; captured result = 0; result_valid = 0; stallreq = 0.
- **Divider contract**
  - The divider samples start only while it is free. Operands must stay stable while start is high.
  - div_done stays high, with div_result valid, until start is seen low. Cancel is honoured only while the divider is computing.
  - A zero divisor yields result 0.
- **IDLE**
  - div_req && !flush:
    - stallreq = 1.
    - Register div_start = 1, div_sign = div_signed, div_opdata1/2 = opnd1/2.
    - Go to BUSY.
  - div_done is ignored in IDLE.
- **BUSY**
  - div_start stays 1. Operands are frozen.
  - Without div_done: stallreq = 1.
  - With div_done:
    - stallreq = 0, result_valid = 1, result_o = div_result (combinational pass-through).
    - Capture div_result. Register div_start = 0.
    - Go to HOLD if ex_stall, otherwise go to IDLE.
- **HOLD**
  - result_o = captured value, result_valid = 1, stallreq = 0, div_start = 0.
  - Go to IDLE when !ex_stall.
  - No new start is issued from HOLD.
- **flush** (any state; highest priority)
  - Register div_cancel = 1 for one cycle and div_start = 0.
  - Go to IDLE. result_valid = 0 and stallreq = 0 in the flush cycle.
  - No HI/LO result is produced.
- **Start spacing**: div_start is low for at least one cycle between operations, because IDLE always lasts at least one cycle. This lets the divider leave its end state and drop div_done before the next start.
- **Reset mid-operation**: the controller returns to IDLE with all outputs at reset values. The divider resets on the same rst.

## Timing
- **Cycle 0**: IDLE, div_req. stallreq = 1.
- **Cycle 1**: div_start visible at the divider.
- **Done cycle**: the divider's done arrives 35 cycles after start (cycle 36 for a normal divide; earlier for a zero divisor).
  - The controller releases stallreq combinationally in the first cycle div_done = 1.
  - The instruction advances at the end of that cycle unless ex_stall is high.
- **stallreq** is never high in the same cycle as result_valid.
- **Cancel**: div_cancel rises one cycle after flush and lasts exactly one cycle.
- **Simultaneous div_done and flush**: flush wins. The result is discarded.

## Configuration
- DIV_CTRL_FASTPATH_EN
  - Defined: in IDLE, a divisor of 0 or 1 is resolved without the divider. Divisor 0 → result 0. Divisor 1 → HI = 0, LO = opnd1, for both signed and unsigned.
    - result_valid = 1 and stallreq = 0 in the request cycle. div_start is not asserted.
    - Go to HOLD if ex_stall; otherwise stay in IDLE.
  - Undefined: all divides go through the divider.

## Structure
- Shared defines: controller state encodings (IDLE/BUSY/HOLD), DivStart/DivStop, DivCancel/DivNoCancel.
- Existing DivResultReady/NotReady and zeroword constants are reused.
- Single module with no sub-module. The divider is instantiated beside this block at EX level, not inside it.

## Test plan
- **Unsigned divide**: DIVU 100/7, no stalls → stallreq high from cycle 0 until div_done; result_o = {0x00000002, 0x0000000E}, result_valid for exactly one cycle.
- **Signed divide**: DIV -7/2 (0xFFFFFFF9 / 0x00000002) → result_o = {0xFFFFFFFF, 0xFFFFFFFD}; div_sign = 1 throughout BUSY.
- **Flush mid-operation**: flush 10 cycles after start → div_cancel one-cycle pulse, div_start = 0, no result_valid. A new DIVU 9/3 issued two cycles later → {0, 3}.
- **Downstream stall at done**: ex_stall = 1 for 3 cycles from the done cycle → result_valid held 4 cycles with a constant result_o, div_start low, no restart.
- **Zero divisor, macro undefined**: DIVU 5/0 → divider path, result 0, stallreq released on div_done.
- **Fast path, DIV_CTRL_FASTPATH_EN defined**: DIV 0x80000000/1 → same-cycle result {0, 0x80000000}, div_start never asserted.
